// File: rtl/delay_pipe_arb.sv
// delay_pipe_arb: round-robin arbiter feeding a shared fixed-latency, stallable register pipeline
module delay_pipe_arb #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 3,
   parameter int IDW   = 2,
   parameter int CNTW  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid_i,
   input  logic [NREQ*WIDTH-1:0] req_data_i,
   output logic [NREQ-1:0]       req_ready_o,
   output logic                  out_valid_o,
   output logic [WIDTH-1:0]      out_data_o,
   output logic [IDW-1:0]        out_id_o,
   input  logic                  out_ready_i,
   output logic [CNTW-1:0]       occupancy_o,
   output logic                  idle_o
);
   logic [DEPTH-1:0]            vld_q, vld_d;
   logic [DEPTH-1:0][WIDTH-1:0] dat_q, dat_d;
   logic [DEPTH-1:0][IDW-1:0]   id_q, id_d;
   logic [IDW-1:0]              ptr_q, ptr_d, win;
   logic [CNTW-1:0]             occ_q, occ_d;
   logic [NREQ-1:0]             rot;
   logic [IDW:0]                sum;
   logic [WIDTH-1:0]            wdat;
   logic                        found, adv, acc, pop;

   assign adv = !vld_q[DEPTH-1] || out_ready_i;
   assign acc = found && adv && rst_n;
   assign pop = vld_q[DEPTH-1] && out_ready_i;
   assign rot = NREQ'({req_valid_i, req_valid_i} >> ptr_q);
   assign win = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : sum[IDW-1:0];

   // first requester at or after ptr_q (searching the rotated vector downward so the nearest wins)
   always_comb begin
      found = 1'b0;
      sum   = '0;
      for (int k = NREQ-1; k >= 0; k--)
         if (rot[k]) begin
            found = 1'b1;
            sum   = {1'b0, ptr_q} + (IDW+1)'(k);
         end
   end

   // mux out the winning requester's data
   always_comb begin
      wdat = '0;
      for (int k = 0; k < NREQ; k++)
         if (win == IDW'(k)) wdat = req_data_i[k*WIDTH +: WIDTH];
   end

   // shift every stage (bubbles included) on advance, load stage 0 with the grant or a bubble
   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      id_d  = id_q;
      if (adv) begin
         for (int i = DEPTH-1; i > 0; i--) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
            id_d[i]  = id_q[i-1];
         end
         vld_d[0] = acc;
         dat_d[0] = acc ? wdat : '0;
         id_d[0]  = acc ? win : '0;
      end
      ptr_d = acc ? ((win == IDW'(NREQ-1)) ? '0 : win + 1'b1) : ptr_q;
      occ_d = occ_q + CNTW'(acc) - CNTW'(pop);
   end

   // state registers, cleared asynchronously so in-flight beats vanish at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         dat_q <= '0;
         id_q  <= '0;
         ptr_q <= '0;
         occ_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
         id_q  <= id_d;
         ptr_q <= ptr_d;
         occ_q <= occ_d;
      end
   end

   assign req_ready_o = acc ? NREQ'(1) << win : '0;
   assign out_valid_o = vld_q[DEPTH-1];
   assign out_data_o  = dat_q[DEPTH-1];
   assign out_id_o    = id_q[DEPTH-1];
   assign occupancy_o = occ_q;
   assign idle_o      = (occ_q == '0) && !(|req_valid_i);
endmodule

// File: doc/delay_pipe_arb.md
Name: delay_pipe_arb

Overview:
- Shares one fixed-latency flop-delay pipeline between NREQ requesters in the router demo.
- A round-robin arbiter picks one requester per cycle.
- The winner's data and requester ID are pushed into a DEPTH-stage register pipeline and emerge DEPTH cycles later, tagged with the ID.
- A single output ready stalls the whole pipeline. An occupancy counter reports the number of beats in flight.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, data width per beat
DEPTH, 3, pipeline stages; must be >=1
IDW, 2, width of requester ID; must be >= clog2(NREQ)
CNTW, 2, occupancy counter width; must be >= clog2(DEPTH+1)

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester beat valid
req_data  input  NREQ*WIDTH  per-requester data; requester i at bits [i*WIDTH +: WIDTH]
req_ready  output  NREQ  one-hot accept; beat i transfers when req_valid[i] && req_ready[i]
out_valid  output  1  last pipeline stage holds a beat
out_data  output  WIDTH  data of last stage
out_id  output  IDW  requester index of last stage
out_ready  input  1  downstream accepts the out beat
occupancy  output  CNTW  beats currently held in pipeline stages
idle  output  1  high when occupancy==0 and no req_valid asserted

Behaviour:
- Reset (rst_n low, asynchronous):
  - Clears all stage valid bits, stage data/id registers, occupancy and the RR pointer.
  - Outputs during and after reset: out_valid=0, out_data=0, out_id=0, occupancy=0, req_ready=0.
  - Deassertion is used synchronously on the next clk edge.
- Advance condition: adv = !out_valid || out_ready.
  - adv=1: every stage shifts one position toward the output and stage 0 loads the arbitration result.
  - adv=0: all stages, including bubbles, hold their contents.
  - Bubbles are not collapsed, so latency is fixed.
- Arbitration (combinational, evaluated every cycle):
  - Search req_valid starting at index ptr, then ptr+1, wrapping modulo NREQ; the first set bit wins.
  - req_ready[winner] = adv; all other req_ready bits = 0.
  - No valid requests → no grant; stage 0 loads a bubble (valid=0).
  - req_ready depends combinationally on req_valid. A requester must hold valid and data stable until it sees ready; it must not wait for ready before raising valid.
- RR pointer:
  - On each accepted beat from requester w, ptr <= (w+1) mod NREQ, wrapping from NREQ-1 to 0.
  - No accept → ptr holds.
- Latency:
  - A beat accepted at edge t has out_valid=1 after edge t+DEPTH-1, i.e. it is visible DEPTH cycles after the cycle in which req_valid && req_ready.
  - Each stall cycle (adv=0) adds one cycle.
  - Throughput is one beat per cycle when out_ready is held high.
- out_data and out_id are driven directly from the last-stage registers; no combinational path from req_* to out_*.
- Occupancy:
  - +1 on accept only; -1 on out handshake (out_valid && out_ready) only; unchanged when both occur or neither.
  - Never exceeds DEPTH and never underflows.
- Stall with a full pipeline: all req_ready=0; pending requesters keep valid. Arbitration resumes on the first cycle with out_ready=1.
- Reset mid-operation: all in-flight beats are discarded, with no output handshake; ptr returns to 0.

Test Plan:
- Reset with req_valid=4'b1111 held → out_valid=0, occupancy=0, req_ready=0 while rst_n=0; first grant after release goes to requester 0.
- Requester 2 alone sends data 0xA5, out_ready=1, DEPTH=3 → out_valid=1, out_data=0xA5, out_id=2 exactly 3 cycles after the accept cycle; occupancy goes 1,1,1 then 0 after the out handshake.
- All four requesters valid continuously, out_ready=1 → grant order 0,1,2,3,0,1 and out_id sequence identical, one beat per cycle.
- Pipeline full (occupancy=3), out_ready=0 for 5 cycles → out_valid/out_data/out_id stable, req_ready=0, occupancy=3; on out_ready=1, beats drain in order and a new accept occurs in the same cycle, keeping occupancy at 3.
- Only requesters 3 and 1 valid, ptr=2 → requester 3 wins; next cycle ptr=0 and requester 1 wins (wrap-around check).
- Assert rst_n=0 asynchronously, mid-clock, with 2 beats in flight → out_valid and occupancy drop to 0 immediately; after release, no stale beat ever appears on the output.
